// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array and its output-side logic.
package systolic_pkg;

    localparam int unsigned W                = 16;
    localparam int unsigned DATA_WIDTH_ACCUM = 32;
    localparam int unsigned COL_CNT_WIDTH    = $clog2(W + 1);

    typedef logic signed [DATA_WIDTH_ACCUM-1:0] acc_vec_t [W];

    // Lower `cols` bits set; shared with the array's pe_enabled logic.
    function automatic logic [W-1:0] col_mask(input logic [COL_CNT_WIDTH-1:0] cols);
        logic [W-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < W; i++) begin
            mask[i] = (i < 32'(cols));
        end
        return mask;
    endfunction

endpackage

// File: rtl/acc_vec_fifo.sv
// Synchronous show-ahead FIFO of accumulator row vectors with a synchronous flush.
module acc_vec_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic                 i_push,
    input  logic signed [DW-1:0] i_push_data [W],
    input  logic                 i_pop,
    output logic signed [DW-1:0] o_head [W],
    output logic                 o_empty,
    output logic                 o_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic signed [DW-1:0] r_mem [DEPTH][W];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic                 w_wr_en;
    logic                 w_rd_en;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr_en = i_push && (!o_full || i_pop);
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !i_flush) begin
            for (int unsigned c = 0; c < W; c++) begin
                r_mem[r_wr_ptr][c] <= i_push_data[c];
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < W; c++) begin
            o_head[c] = o_empty ? '0 : r_mem[r_rd_ptr][c];
        end
    end

endmodule

// File: rtl/systolic_output_deskew.sv
// Re-aligns the skewed per-column psum outputs of the systolic array into row vectors
// and hands them downstream through a FIFO on a valid/ready handshake.
module systolic_output_deskew #(
    parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int unsigned DATA_WIDTH_ACCUM     = 32,
    parameter int unsigned FIFO_DEPTH           = 8,
    parameter int unsigned ROW_CNT_WIDTH        = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cfg_valid,
    input  logic [$clog2(SYSTOLIC_ARRAY_WIDTH+1)-1:0] cfg_cols,
    input  logic [ROW_CNT_WIDTH-1:0]           cfg_rows,
    input  logic signed [DATA_WIDTH_ACCUM-1:0] in_data [SYSTOLIC_ARRAY_WIDTH],
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]    in_valid,
    output logic signed [DATA_WIDTH_ACCUM-1:0] out_data [SYSTOLIC_ARRAY_WIDTH],
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic                               err_overflow,
    output logic                               err_misalign
);

    import systolic_pkg::*;

    localparam int unsigned AW = SYSTOLIC_ARRAY_WIDTH;
    localparam int unsigned DW = DATA_WIDTH_ACCUM;

    logic [AW-1:0]            r_col_en;
    logic [ROW_CNT_WIDTH-1:0] r_rows;
    logic [ROW_CNT_WIDTH-1:0] r_row_cnt;
    logic                     r_err_ovf;
    logic                     r_err_mis;

    logic signed [DW-1:0] w_dsk_data [AW];
    logic [AW-1:0]        w_dsk_vld;
    logic [AW-1:0]        w_vld_act;
    logic signed [DW-1:0] w_push_data [AW];
    logic                 w_aligned;
    logic                 w_misalign;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_last_hit;

    // Column j sees W-j stages so that all columns of one row leave together.
    for (genvar j = 0; j < int'(AW); j++) begin : g_col
        localparam int unsigned DEPTH_J = AW - j;

        logic signed [DW-1:0] r_dly_data [DEPTH_J];
        logic [DEPTH_J-1:0]   r_dly_vld;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dly_vld <= '0;
            end else if (cfg_valid) begin
                r_dly_vld <= '0;
            end else begin
                r_dly_vld[0] <= in_valid[j];
                for (int unsigned k = 1; k < DEPTH_J; k++) begin
                    r_dly_vld[k] <= r_dly_vld[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            r_dly_data[0] <= in_data[j];
            for (int unsigned k = 1; k < DEPTH_J; k++) begin
                r_dly_data[k] <= r_dly_data[k-1];
            end
        end

        assign w_dsk_data[j] = r_dly_data[DEPTH_J-1];
        assign w_dsk_vld[j]  = r_dly_vld[DEPTH_J-1];
    end

    always_comb begin
        w_vld_act  = w_dsk_vld & r_col_en;
        w_aligned  = (r_col_en != '0) && (w_vld_act == r_col_en);
        w_misalign = (w_vld_act != '0) && !w_aligned;
        for (int unsigned c = 0; c < AW; c++) begin
            w_push_data[c] = r_col_en[c] ? w_dsk_data[c] : '0;
        end
    end

    assign out_valid  = !w_empty;
    assign w_pop      = out_valid && out_ready;
    assign w_drop     = w_aligned && w_full && !w_pop;
    assign w_last_hit = (r_rows != '0) && (r_row_cnt == r_rows - ROW_CNT_WIDTH'(1));
    assign out_last   = out_valid && w_last_hit;

    assign err_overflow = r_err_ovf;
    assign err_misalign = r_err_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_en  <= '0;
            r_rows    <= '0;
            r_row_cnt <= '0;
            r_err_ovf <= 1'b0;
            r_err_mis <= 1'b0;
        end else if (cfg_valid) begin
            r_col_en  <= col_mask(cfg_cols);
            r_rows    <= cfg_rows;
            r_row_cnt <= '0;
            r_err_ovf <= 1'b0;
            r_err_mis <= 1'b0;
        end else begin
            if (w_pop) begin
                r_row_cnt <= w_last_hit ? '0 : r_row_cnt + ROW_CNT_WIDTH'(1);
            end
            if (w_drop)     r_err_ovf <= 1'b1;
            if (w_misalign) r_err_mis <= 1'b1;
        end
    end

    acc_vec_fifo #(
        .W     (AW),
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (cfg_valid),
        .i_push      (w_aligned),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (out_data),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed bench for systolic_output_deskew: table of single-tile scenarios plus
// hand-written overflow, flush and asynchronous-reset sequences.
module tb_systolic_output_deskew;

    localparam int W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic [4:0]        cfg_cols;
    logic [15:0]       cfg_rows;
    logic signed [31:0] in_data [W];
    logic [W-1:0]      in_valid;
    logic signed [31:0] out_data [W];
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              err_overflow;
    logic              err_misalign;

    int n_checks = 0;
    int n_pass   = 0;

    logic signed [31:0] pop_d [32][W];
    logic               pop_l [32];
    int                 pop_n;

    typedef struct {
        int cols;
        int rows_cfg;
        int nrows;
        int gap;
        int late_col;
        int sgn;
        int exp_pops;
        int exp_mis;
        int exp_first;
    } vec_t;

    vec_t tbl [6];

    systolic_output_deskew #(
        .SYSTOLIC_ARRAY_WIDTH (16),
        .DATA_WIDTH_ACCUM     (32),
        .FIFO_DEPTH           (8),
        .ROW_CNT_WIDTH        (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_cols     (cfg_cols),
        .cfg_rows     (cfg_rows),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .err_overflow (err_overflow),
        .err_misalign (err_misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    function automatic logic signed [31:0] val(input int r, input int j, input int sgn);
        return 32'(sgn * (100 * r + j));
    endfunction

    function automatic logic signed [31:0] exp_col(input int r, input int j, input int cols, input int sgn);
        return (j < cols) ? val(r, j, sgn) : 32'sd0;
    endfunction

    task automatic apply_cfg(input int cols, input int rows);
        cfg_valid = 1'b1;
        cfg_cols  = 5'(cols);
        cfg_rows  = 16'(rows);
        tick();
        cfg_valid = 1'b0;
        pop_n     = 0;
    endtask

    task automatic record_pop();
        if (pop_n < 32) begin
            for (int j = 0; j < W; j++) pop_d[pop_n][j] = out_data[j];
            pop_l[pop_n] = out_last;
        end
        pop_n++;
    endtask

    // Row r of column j enters at cycle r*gap+j; one (late_row, late_col) element slips a cycle.
    // ready_mode: 0 always ready, 1 never ready, 2 ready only in cycle ready_cyc.
    task automatic stream(input int cols, input int nrows, input int gap, input int late_row,
                          input int late_col, input int sgn, input int ready_mode,
                          input int ready_cyc, output int first_v);
        int ncyc;
        ncyc    = (nrows - 1) * gap + W + 6;
        first_v = -1;
        for (int c = 0; c < ncyc; c++) begin
            for (int j = 0; j < W; j++) begin
                in_valid[j] = 1'b0;
                in_data[j]  = '0;
                if (j >= cols) begin
                    in_valid[j] = 1'b1;
                    in_data[j]  = 32'h0000DEAD;
                end else begin
                    for (int r = 0; r < nrows; r++) begin
                        if (r * gap + j + ((r == late_row && j == late_col) ? 1 : 0) == c) begin
                            in_valid[j] = 1'b1;
                            in_data[j]  = val(r, j, sgn);
                        end
                    end
                end
            end
            out_ready = (ready_mode == 0) || (ready_mode == 2 && c == ready_cyc);
            if (out_valid && first_v < 0) first_v = c;
            if (out_valid && out_ready) record_pop();
            tick();
        end
        in_valid  = '0;
        for (int j = 0; j < W; j++) in_data[j] = '0;
        out_ready = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!out_valid) break;
            record_pop();
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic check_pop(input int k, input int r, input int cols, input int sgn);
        int jm;
        jm = -1;
        for (int j = 0; j < W; j++) begin
            if (jm < 0 && pop_d[k][j] != exp_col(r, j, cols, sgn)) jm = j;
        end
        if (jm < 0) jm = W - 1;
        chk($sformatf("pop%0d_row%0d_col%0d", k, r, jm), pop_d[k][jm], exp_col(r, jm, cols, sgn));
    endtask

    initial begin
        int first_v;
        int k;
        int late_row;

        tbl[0] = '{cols:16, rows_cfg:4, nrows:4, gap:1, late_col:-1, sgn: 1, exp_pops:4, exp_mis:0, exp_first:17};
        tbl[1] = '{cols: 4, rows_cfg:2, nrows:3, gap:1, late_col:-1, sgn: 1, exp_pops:3, exp_mis:0, exp_first:17};
        tbl[2] = '{cols:16, rows_cfg:0, nrows:2, gap:2, late_col: 3, sgn: 1, exp_pops:1, exp_mis:1, exp_first:19};
        tbl[3] = '{cols: 1, rows_cfg:1, nrows:2, gap:3, late_col:-1, sgn:-1, exp_pops:2, exp_mis:0, exp_first:17};
        tbl[4] = '{cols: 0, rows_cfg:1, nrows:2, gap:1, late_col:-1, sgn: 1, exp_pops:0, exp_mis:0, exp_first:-1};
        tbl[5] = '{cols:15, rows_cfg:3, nrows:3, gap:1, late_col:-1, sgn:-1, exp_pops:3, exp_mis:0, exp_first:17};

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_cols  = '0;
        cfg_rows  = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int j = 0; j < W; j++) in_data[j] = '0;
        pop_n = 0;

        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err_overflow", err_overflow, 0);
        chk("rst_err_misalign", err_misalign, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_out_data0", out_data[0], 0);

        foreach (tbl[t]) begin
            apply_cfg(tbl[t].cols, tbl[t].rows_cfg);
            late_row = (tbl[t].late_col >= 0) ? 0 : -1;
            stream(tbl[t].cols, tbl[t].nrows, tbl[t].gap, late_row, tbl[t].late_col,
                   tbl[t].sgn, 0, 0, first_v);
            chk($sformatf("t%0d_pops", t), pop_n, tbl[t].exp_pops);
            chk($sformatf("t%0d_first_valid", t), first_v, tbl[t].exp_first);
            chk($sformatf("t%0d_err_misalign", t), err_misalign, tbl[t].exp_mis);
            chk($sformatf("t%0d_err_overflow", t), err_overflow, 0);
            k = 0;
            for (int r = 0; r < tbl[t].nrows; r++) begin
                if (tbl[t].cols == 0 || (late_row == r && tbl[t].late_col < tbl[t].cols)) continue;
                if (k < pop_n && k < 32) begin
                    check_pop(k, r, tbl[t].cols, tbl[t].sgn);
                    chk($sformatf("t%0d_pop%0d_last", t, k), pop_l[k],
                        (tbl[t].rows_cfg != 0 && (k % tbl[t].rows_cfg) == tbl[t].rows_cfg - 1) ? 1 : 0);
                end
                k++;
            end
        end

        // Overflow: 9 vectors into a depth-8 FIFO with no ready.
        apply_cfg(16, 0);
        stream(16, 9, 1, -1, -1, 1, 1, 0, first_v);
        chk("ovf_no_pop", pop_n, 0);
        chk("ovf_out_valid", out_valid, 1);
        chk("ovf_err_overflow", err_overflow, 1);
        chk("ovf_head_col7", out_data[7], 7);
        drain();
        chk("ovf_drained", pop_n, 8);
        for (int i = 0; i < 8; i++) check_pop(i, i, 16, 1);
        chk("ovf_sticky", err_overflow, 1);

        // Full FIFO with a pop in the push cycle keeps the 9th vector.
        apply_cfg(16, 0);
        chk("cfg_clears_overflow", err_overflow, 0);
        stream(16, 9, 1, -1, -1, 1, 2, 24, first_v);
        chk("fullpop_one_pop", pop_n, 1);
        chk("fullpop_no_overflow", err_overflow, 0);
        drain();
        chk("fullpop_total", pop_n, 9);
        for (int i = 0; i < 9; i++) check_pop(i, i, 16, 1);

        // cfg_valid with 3 vectors queued and a misalign flag set.
        apply_cfg(16, 4);
        stream(16, 5, 2, 0, 3, 1, 2, 19, first_v);
        chk("flush_pre_pops", pop_n, 1);
        check_pop(0, 1, 16, 1);
        chk("flush_pre_misalign", err_misalign, 1);
        chk("flush_pre_valid", out_valid, 1);
        apply_cfg(16, 2);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_err_misalign", err_misalign, 0);
        stream(16, 2, 1, -1, -1, 1, 0, 0, first_v);
        chk("flush_post_pops", pop_n, 2);
        chk("flush_pop0_last", pop_l[0], 0);
        chk("flush_pop1_last", pop_l[1], 1);

        // Asynchronous reset between clock edges while vectors are queued.
        apply_cfg(16, 4);
        stream(16, 9, 1, -1, -1, 1, 1, 0, first_v);
        chk("arst_pre_valid", out_valid, 1);
        chk("arst_pre_overflow", err_overflow, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data5", out_data[5], 0);
        chk("arst_err_overflow", err_overflow, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_post_valid", out_valid, 0);
        chk("arst_post_misalign", err_misalign, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
